// File: rtl/sft_sched_pkg.sv
// Shared definitions for the shift-register command scheduler.
//   state_t     : scheduler FSM states
//   cmd_t       : command codes sent to the shift driver
//   TMO_CYC_DEF : default done-wait timeout in cycles
//   pick_byte   : select byte idx (0 = least significant) from a 32-bit word
package sft_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_MR    = 2'b00,
    CMD_SHIFT = 2'b01,
    CMD_LATCH = 2'b10,
    CMD_OE    = 2'b11
  } cmd_t;

  localparam int unsigned TMO_CYC_DEF = 1023;

  function automatic logic [7:0] pick_byte(input logic [31:0] dat, input logic [1:0] idx);
    return dat[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sft_rr_arb.sv
// Two-way round-robin arbiter with a registered priority pointer.
//   CLK_I, RST_I : clock, asynchronous active-high reset
//   i_req        : request vector (bit n = requester n)
//   i_take       : the grant is consumed this cycle (pointer advances)
//   o_vld        : at least one request is present
//   o_idx        : index of the granted requester
module sft_rr_arb (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_vld,
  output logic       o_idx
);

  // Requester favoured on a tie; always the one not served last.
  logic r_prio;
  logic w_idx;

  always_comb begin
    w_idx = 1'b0;
    if (i_req == 2'b11) w_idx = r_prio;
    else                w_idx = i_req[1];
  end

  assign o_vld = |i_req;
  assign o_idx = w_idx;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)               r_prio <= 1'b0;
    else if (i_take && o_vld) r_prio <= ~w_idx;
  end

endmodule

// File: rtl/sft_sched.sv
// Scheduler that serialises requests from two clients into command
// sequences for a shift-register driver: optional master reset, shift
// bytes (MSB first), storage latch, output enable. Each command waits for
// SFT_DONE_I; a missing done aborts the sequence with ERR_O set.
//   CLK_I, RST_I         : clock, asynchronous active-high reset
//   REQx_I               : request, held until ACKx_O
//   DATx_I, CNTx_I       : payload bytes and byte count minus one
//   MRx_I, OENx_I        : master reset enable, final OE value
//   ACKx_O, ERR_O        : end-of-sequence pulse and its timeout status
//   BUSY_O               : FSM not idle
//   SFT_VLD_O/CMD/OEN/DIN: command strobe and fields to the driver
//   SFT_DONE_I           : driver completion pulse
module sft_sched
  import sft_sched_pkg::*;
#(
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        REQ0_I,
  input  logic        REQ1_I,
  input  logic [31:0] DAT0_I,
  input  logic [31:0] DAT1_I,
  input  logic [1:0]  CNT0_I,
  input  logic [1:0]  CNT1_I,
  input  logic        MR0_I,
  input  logic        MR1_I,
  input  logic        OEN0_I,
  input  logic        OEN1_I,
  output logic        ACK0_O,
  output logic        ACK1_O,
  output logic        ERR_O,
  output logic        BUSY_O,
  output logic        SFT_VLD_O,
  output logic [1:0]  SFT_CMD_O,
  output logic        SFT_OEN_O,
  output logic [7:0]  SFT_DIN_O,
  input  logic        SFT_DONE_I
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  state_t        r_state;
  cmd_t          r_cur;
  logic          r_busy;
  logic          r_vld;
  logic [1:0]    r_cmd;
  logic [7:0]    r_din;
  logic          r_oen;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_err;
  logic          r_abort;
  logic          r_gidx;
  logic [31:0]   r_dat;
  logic [1:0]    r_bidx;
  logic [CW-1:0] r_wcnt;

  logic w_gnt_vld;
  logic w_gnt_idx;

  sft_rr_arb u_arb (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .i_req  ({REQ1_I, REQ0_I}),
    .i_take (r_state == ST_IDLE),
    .o_vld  (w_gnt_vld),
    .o_idx  (w_gnt_idx)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state <= ST_IDLE;
      r_cur   <= CMD_MR;
      r_busy  <= 1'b0;
      r_vld   <= 1'b0;
      r_cmd   <= '0;
      r_din   <= '0;
      r_oen   <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= 1'b0;
      r_gidx  <= 1'b0;
      r_dat   <= '0;
      r_bidx  <= '0;
      r_wcnt  <= '0;
    end else begin
      r_vld  <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_gidx  <= w_gnt_idx;
            r_dat   <= w_gnt_idx ? DAT1_I : DAT0_I;
            r_bidx  <= w_gnt_idx ? CNT1_I : CNT0_I;
            r_oen   <= w_gnt_idx ? OEN1_I : OEN0_I;
            // MR is consumed here by choosing the first command.
            r_cur   <= (w_gnt_idx ? MR1_I : MR0_I) ? CMD_MR : CMD_SHIFT;
            r_abort <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_vld   <= 1'b1;
          r_cmd   <= r_cur;
          r_din   <= (r_cur == CMD_SHIFT) ? pick_byte(r_dat, r_bidx) : '0;
          r_wcnt  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done is checked before the timeout so a done in the final
          // allowed cycle (count TMO_CYC-1, the TMO_CYC-th) still succeeds.
          if (SFT_DONE_I) begin
            case (r_cur)
              CMD_MR: begin
                r_cur   <= CMD_SHIFT;
                r_state <= ST_ISSUE;
              end
              CMD_SHIFT: begin
                if (r_bidx == 2'd0) r_cur  <= CMD_LATCH;
                else                r_bidx <= r_bidx - 2'd1;
                r_state <= ST_ISSUE;
              end
              CMD_LATCH: begin
                r_cur   <= CMD_OE;
                r_state <= ST_ISSUE;
              end
              default: r_state <= ST_RESP;
            endcase
          end else if (r_wcnt == CW'(TMO_CYC - 1)) begin
            r_abort <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: begin
          r_ack0  <= ~r_gidx;
          r_ack1  <= r_gidx;
          r_err   <= r_abort;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ACK0_O    = r_ack0;
  assign ACK1_O    = r_ack1;
  assign ERR_O     = r_err;
  assign BUSY_O    = r_busy;
  assign SFT_VLD_O = r_vld;
  assign SFT_CMD_O = r_cmd;
  assign SFT_OEN_O = r_oen;
  assign SFT_DIN_O = r_din;

endmodule

// File: tb/tb_sft_sched.sv
// Directed bench for sft_sched: command order and bytes, round-robin
// grants, timeout boundary, mid-sequence reset and dropped requests.
module tb_sft_sched;

  localparam int unsigned TMO = 16;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        REQ0_I, REQ1_I;
  logic [31:0] DAT0_I, DAT1_I;
  logic [1:0]  CNT0_I, CNT1_I;
  logic        MR0_I, MR1_I, OEN0_I, OEN1_I;
  logic        ACK0_O, ACK1_O, ERR_O, BUSY_O, SFT_VLD_O, SFT_OEN_O;
  logic [1:0]  SFT_CMD_O;
  logic [7:0]  SFT_DIN_O;
  logic        SFT_DONE_I;

  sft_sched #(.TMO_CYC(TMO)) u_dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .REQ0_I     (REQ0_I),
    .REQ1_I     (REQ1_I),
    .DAT0_I     (DAT0_I),
    .DAT1_I     (DAT1_I),
    .CNT0_I     (CNT0_I),
    .CNT1_I     (CNT1_I),
    .MR0_I      (MR0_I),
    .MR1_I      (MR1_I),
    .OEN0_I     (OEN0_I),
    .OEN1_I     (OEN1_I),
    .ACK0_O     (ACK0_O),
    .ACK1_O     (ACK1_O),
    .ERR_O      (ERR_O),
    .BUSY_O     (BUSY_O),
    .SFT_VLD_O  (SFT_VLD_O),
    .SFT_CMD_O  (SFT_CMD_O),
    .SFT_OEN_O  (SFT_OEN_O),
    .SFT_DIN_O  (SFT_DIN_O),
    .SFT_DONE_I (SFT_DONE_I)
  );

  initial forever #5 CLK_I = ~CLK_I;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [1:0] cmd; logic [7:0] din; logic oen; int cyc; } vld_t;
  typedef struct { logic who; logic err; logic busy; int cyc; } ack_t;

  vld_t q_v[$];
  ack_t q_a[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   dly   = 0;   // done delay after each VLD; 0 = never answer
  int   dcnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: wait for the falling edge, then sample outputs and drive
  // the done responder and the requesters' release on ACK.
  task automatic tick();
    @(negedge CLK_I);
    cyc++;
    SFT_DONE_I = 1'b0;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) SFT_DONE_I = 1'b1;
    end
    if (SFT_VLD_O) begin
      q_v.push_back('{cmd:SFT_CMD_O, din:SFT_DIN_O, oen:SFT_OEN_O, cyc:cyc});
      if (dly > 0) dcnt = dly;
    end
    if (ACK0_O) begin
      q_a.push_back('{who:1'b0, err:ERR_O, busy:BUSY_O, cyc:cyc});
      REQ0_I = 1'b0;
    end
    if (ACK1_O) begin
      q_a.push_back('{who:1'b1, err:ERR_O, busy:BUSY_O, cyc:cyc});
      REQ1_I = 1'b0;
    end
  endtask

  function automatic vld_t get_v(input int i);
    vld_t v;
    v = '{cmd:2'b00, din:8'hEE, oen:1'b0, cyc:-1};
    if (i < q_v.size()) v = q_v[i];
    return v;
  endfunction

  function automatic ack_t get_a(input int i);
    ack_t a;
    a = '{who:1'bx, err:1'bx, busy:1'bx, cyc:-1};
    if (i < q_a.size()) a = q_a[i];
    return a;
  endfunction

  task automatic clear();
    q_v.delete();
    q_a.delete();
    dcnt = 0;
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int k = 0;
    while (q_a.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_ack_seen"}, 32'(q_a.size() >= n), 32'd1);
  endtask

  task automatic chk_vld(input string tag, input int i, input logic [1:0] cmd, input logic [7:0] din);
    vld_t v;
    v = get_v(i);
    chk($sformatf("%s_cmd%0d", tag, i), 32'(v.cmd), 32'(cmd));
    chk($sformatf("%s_din%0d", tag, i), 32'(v.din), 32'(din));
  endtask

  task automatic chk_ack(input string tag, input int i, input logic who, input logic err);
    ack_t a;
    a = get_a(i);
    chk($sformatf("%s_who%0d", tag, i), 32'(a.who), 32'(who));
    chk($sformatf("%s_err%0d", tag, i), 32'(a.err), 32'(err));
  endtask

  initial begin
    vld_t v;
    ack_t a;
    int   t0;
    int   k;

    RST_I = 1'b1; REQ0_I = 1'b0; REQ1_I = 1'b0;
    DAT0_I = '0; DAT1_I = '0; CNT0_I = '0; CNT1_I = '0;
    MR0_I = 1'b0; MR1_I = 1'b0; OEN0_I = 1'b0; OEN1_I = 1'b0;
    SFT_DONE_I = 1'b0;
    repeat (3) tick();
    chk("rst_outs", 32'({BUSY_O, SFT_VLD_O, ACK0_O, ACK1_O, ERR_O, SFT_CMD_O, SFT_OEN_O, SFT_DIN_O}), 32'd0);
    RST_I = 1'b0;
    tick();

    // MR + two bytes, done 5 cycles after each VLD.
    clear(); dly = 5;
    DAT0_I = 32'h0000A55A; CNT0_I = 2'd1; MR0_I = 1'b1; OEN0_I = 1'b0; REQ0_I = 1'b1;
    t0 = cyc;
    wait_acks(1, 200, "t1");
    chk("t1_nvld", 32'(q_v.size()), 32'd5);
    chk_vld("t1", 0, 2'b00, 8'h00);
    chk_vld("t1", 1, 2'b01, 8'hA5);
    chk_vld("t1", 2, 2'b01, 8'h5A);
    chk_vld("t1", 3, 2'b10, 8'h00);
    chk_vld("t1", 4, 2'b11, 8'h00);
    v = get_v(0);
    chk("t1_req_to_vld", 32'(v.cyc - t0), 32'd2);
    v = get_v(4);
    chk("t1_oe_val", 32'(v.oen), 32'd0);
    a = get_a(0);
    chk("t1_done_to_ack", 32'(a.cyc - v.cyc), 32'd7);
    chk("t1_busy_at_ack", 32'(a.busy), 32'd0);
    chk_ack("t1", 0, 1'b0, 1'b0);

    // Round robin after reset: 0,1 then again 0,1.
    RST_I = 1'b1; tick(); tick(); RST_I = 1'b0;
    clear(); dly = 2;
    DAT0_I = 32'h000000AA; CNT0_I = 2'd0; MR0_I = 1'b0; OEN0_I = 1'b1;
    DAT1_I = 32'h000000BB; CNT1_I = 2'd0; MR1_I = 1'b0; OEN1_I = 1'b0;
    REQ0_I = 1'b1; REQ1_I = 1'b1;
    wait_acks(2, 200, "t2a");
    REQ0_I = 1'b1; REQ1_I = 1'b1;
    wait_acks(4, 200, "t2b");
    chk("t2_nvld", 32'(q_v.size()), 32'd12);
    for (int i = 0; i < 4; i++) begin
      chk_ack("t2", i, 1'(i & 1), 1'b0);
      chk_vld("t2", 3*i,     2'b01, (i & 1) ? 8'hBB : 8'hAA);
      chk_vld("t2", 3*i + 1, 2'b10, 8'h00);
      chk_vld("t2", 3*i + 2, 2'b11, 8'h00);
      v = get_v(3*i + 2);
      chk($sformatf("t2_oen%0d", i), 32'(v.oen), 32'((i & 1) == 0));
    end

    // Timeout: done never returned.
    clear(); dly = 0;
    DAT0_I = 32'h12345678; CNT0_I = 2'd3; MR0_I = 1'b1; OEN0_I = 1'b0; REQ0_I = 1'b1;
    wait_acks(1, 100, "t3");
    repeat (6) tick();
    chk("t3_nvld", 32'(q_v.size()), 32'd1);
    chk_vld("t3", 0, 2'b00, 8'h00);
    chk_ack("t3", 0, 1'b0, 1'b1);
    v = get_v(0); a = get_a(0);
    chk("t3_vld_to_ack", 32'(a.cyc - v.cyc), 32'(TMO + 1));
    chk("t3_nack", 32'(q_a.size()), 32'd1);

    // Done in the last allowed WAIT cycle: success.
    clear(); dly = TMO - 1;
    DAT0_I = 32'h0000005A; CNT0_I = 2'd0; MR0_I = 1'b0; REQ0_I = 1'b1;
    wait_acks(1, 200, "t4a");
    chk("t4a_nvld", 32'(q_v.size()), 32'd3);
    chk_vld("t4a", 0, 2'b01, 8'h5A);
    chk_ack("t4a", 0, 1'b0, 1'b0);
    v = get_v(2); a = get_a(0);
    chk("t4a_done_to_ack", 32'(a.cyc - v.cyc), 32'(TMO + 1));

    // Done one cycle too late: timeout, late done ignored.
    clear(); dly = TMO;
    REQ0_I = 1'b1;
    wait_acks(1, 200, "t4b");
    repeat (4) tick();
    chk("t4b_nvld", 32'(q_v.size()), 32'd1);
    chk_ack("t4b", 0, 1'b0, 1'b1);

    // Reset during the second shift WAIT; REQ1 pending at release.
    clear(); dly = 3;
    DAT0_I = 32'h0000C33C; CNT0_I = 2'd1; MR0_I = 1'b0; OEN0_I = 1'b1; REQ0_I = 1'b1;
    k = 0;
    while (q_v.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    tick();
    chk("t5_busy_pre", 32'(BUSY_O), 32'd1);
    chk("t5_oen_pre", 32'(SFT_OEN_O), 32'd1);
    chk_vld("t5", 1, 2'b01, 8'h3C);
    DAT1_I = 32'h0000007E; CNT1_I = 2'd0; MR1_I = 1'b1; OEN1_I = 1'b1; REQ1_I = 1'b1;
    RST_I = 1'b1;
    #1;
    chk("t5_rst_outs", 32'({BUSY_O, SFT_VLD_O, ACK0_O, ACK1_O, ERR_O, SFT_CMD_O, SFT_OEN_O, SFT_DIN_O}), 32'd0);
    REQ0_I = 1'b0;
    repeat (3) tick();
    RST_I = 1'b0;
    t0 = cyc;
    wait_acks(1, 200, "t5");
    repeat (3) tick();
    chk("t5_nack", 32'(q_a.size()), 32'd1);
    chk_ack("t5", 0, 1'b1, 1'b0);
    chk("t5_nvld", 32'(q_v.size()), 32'd6);
    chk_vld("t5", 2, 2'b00, 8'h00);
    chk_vld("t5", 3, 2'b01, 8'h7E);
    chk_vld("t5", 4, 2'b10, 8'h00);
    chk_vld("t5", 5, 2'b11, 8'h00);
    v = get_v(2);
    chk("t5_rel_to_vld", 32'(v.cyc - t0), 32'd2);
    v = get_v(5);
    chk("t5_oe_val", 32'(v.oen), 32'd1);

    // Four bytes, request dropped after the first command.
    clear(); dly = 1;
    DAT0_I = 32'h11223344; CNT0_I = 2'd3; MR0_I = 1'b0; OEN0_I = 1'b0; REQ0_I = 1'b1;
    k = 0;
    while (q_v.size() < 1 && k < 50) begin
      tick();
      k++;
    end
    REQ0_I = 1'b0;
    wait_acks(1, 200, "t6");
    repeat (3) tick();
    chk("t6_nvld", 32'(q_v.size()), 32'd6);
    chk_vld("t6", 0, 2'b01, 8'h11);
    chk_vld("t6", 1, 2'b01, 8'h22);
    chk_vld("t6", 2, 2'b01, 8'h33);
    chk_vld("t6", 3, 2'b01, 8'h44);
    chk_vld("t6", 4, 2'b10, 8'h00);
    chk_vld("t6", 5, 2'b11, 8'h00);
    chk_ack("t6", 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
